// File: rtl/cmd_byte_assembler_pkg.sv
// Shared types and defaults for the receive-side command assembler.
package cmd_asm_pkg;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/cmd_byte_assembler_if.sv
// UART-side and command-processor-side signals of the assembler.
// master: the assembler itself; slave: the UART and command processor around it.
interface cmd_byte_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        timeout_err;

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent, timeout_err
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent, timeout_err
  );
endinterface

// File: rtl/cmd_byte_assembler_resp_tx_ctrl.sv
// Response path: hands one byte to the UART transmitter per send_resp and
// tracks completion; requests arriving while busy are dropped.
module resp_tx_ctrl
  import cmd_asm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send_resp_i,
  input  logic [7:0] resp_i,
  input  logic       tx_done_i,
  output logic       trmt_o,
  output logic [7:0] tx_data_o,
  output logic       resp_sent_o
);

  tx_state_t  tx_state_q;
  logic       trmt_q;
  logic [7:0] tx_data_q;
  logic       resp_sent_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      trmt_q      <= 1'b0;
      tx_data_q   <= 8'h00;
      resp_sent_q <= 1'b0;
    end else begin
      trmt_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (send_resp_i) begin
            tx_data_q   <= resp_i;
            trmt_q      <= 1'b1;
            resp_sent_q <= 1'b0;
            tx_state_q  <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          // tx_data_q is only loaded in TX_IDLE, so it holds until tx_done.
          if (tx_done_i) begin
            resp_sent_q <= 1'b1;
            tx_state_q  <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign trmt_o      = trmt_q;
  assign tx_data_o   = tx_data_q;
  assign resp_sent_o = resp_sent_q;

endmodule

// File: rtl/cmd_byte_assembler.sv
// Assembles two UART bytes (high first) into a 16-bit command with an
// inter-byte timeout, and forwards one response byte to the UART transmitter.
module cmd_byte_assembler
  import cmd_asm_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int TMR_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                 clk,
  input  logic                 rst,
  cmd_byte_assembler_if.master bus
);

  localparam logic [TMR_W-1:0] TMR_TERM = TMR_W'(TIMEOUT_CYC - 1);

  rx_state_t        rx_state_q;
  logic [7:0]       hi_hold_q;
  logic [15:0]      cmd_q;
  logic             cmd_rdy_q;
  logic             clr_rx_rdy_q;
  logic             timeout_err_q;
  logic [TMR_W-1:0] timer_q;
  logic             take_d;

  // rx_rdy stays high for one cycle after our clear pulse; ignore it then.
  assign take_d = bus.rx_rdy & ~clr_rx_rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q    <= WAIT_HI;
      hi_hold_q     <= 8'h00;
      cmd_q         <= 16'h0000;
      cmd_rdy_q     <= 1'b0;
      clr_rx_rdy_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      clr_rx_rdy_q  <= take_d;
      timeout_err_q <= 1'b0;
      if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      case (rx_state_q)
        WAIT_HI: begin
          if (take_d) begin
            hi_hold_q  <= bus.rx_data;
            cmd_rdy_q  <= 1'b0;
            timer_q    <= '0;
            rx_state_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A byte on the terminal-count cycle still completes the command.
          if (take_d) begin
            cmd_q      <= {hi_hold_q, bus.rx_data};
            cmd_rdy_q  <= 1'b1;
            rx_state_q <= WAIT_HI;
          end else if (timer_q == TMR_TERM) begin
            hi_hold_q     <= 8'h00;
            timeout_err_q <= 1'b1;
            timer_q       <= '0;
            rx_state_q    <= WAIT_HI;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: rx_state_q <= WAIT_HI;
      endcase
    end
  end

  assign bus.clr_rx_rdy  = clr_rx_rdy_q;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.timeout_err = timeout_err_q;

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk         (clk),
    .rst         (rst),
    .send_resp_i (bus.send_resp),
    .resp_i      (bus.resp),
    .tx_done_i   (bus.tx_done),
    .trmt_o      (bus.trmt),
    .tx_data_o   (bus.tx_data),
    .resp_sent_o (bus.resp_sent)
  );

endmodule

// File: tb/tb_cmd_byte_assembler.sv
// Self-checking bench for cmd_byte_assembler with a short timeout.
module tb_cmd_byte_assembler;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_byte_assembler_if bus ();

  cmd_byte_assembler #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_to  = 0;
  int n_clr = 0;
  int n_trmt = 0;

  always @(negedge clk) begin
    if (bus.timeout_err === 1'b1) n_to++;
    if (bus.clr_rx_rdy === 1'b1) n_clr++;
    if (bus.trmt === 1'b1) n_trmt++;
  end

  // UART receiver model: present a byte, keep rx_rdy up one cycle past the
  // clear pulse, report when the byte was taken and what cmd looked like then.
  task automatic send_byte(input logic [7:0] b, input int idle, input bit with_clr,
                           output bit took, output longint t,
                           output logic [15:0] cmd_at, output logic cmd_rdy_at);
    repeat (idle) @(negedge clk);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    if (with_clr) bus.clr_cmd_rdy = 1'b1;
    took = 1'b0;
    t = 0;
    cmd_at = 16'hxxxx;
    cmd_rdy_at = 1'bx;
    for (int i = 0; i < 4 && !took; i++) begin
      @(posedge clk);
      t = longint'($time);
      #1;
      bus.clr_cmd_rdy = 1'b0;
      if (bus.clr_rx_rdy === 1'b1) begin
        took = 1'b1;
        cmd_at = bus.cmd;
        cmd_rdy_at = bus.cmd_rdy;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.cmd, bus.cmd_rdy, bus.clr_rx_rdy, bus.trmt, bus.tx_data, bus.resp_sent, bus.timeout_err} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs: cmd=%h cmd_rdy=%b clr=%b trmt=%b tx_data=%h resp_sent=%b to=%b, all required 0",
               bus.cmd, bus.cmd_rdy, bus.clr_rx_rdy, bus.trmt, bus.tx_data, bus.resp_sent, bus.timeout_err);
    end
  endtask

  task automatic test_basic();
    bit took; longint t; logic [15:0] c; logic r; int clr0, to0;
    clr0 = n_clr; to0 = n_to;
    send_byte(8'hA5, 0, 0, took, t, c, r);
    send_byte(8'h3C, 8, 0, took, t, c, r);
    total++;
    if (c !== 16'hA53C || r !== 1'b1) begin
      bad++;
      $display("FAIL basic_cmd: cmd=%h rdy=%b, required A53C rdy=1", c, r);
    end
    total++;
    if (n_clr - clr0 !== 2 || bus.clr_rx_rdy !== 1'b0) begin
      bad++;
      $display("FAIL basic_clr_pulses: got %0d pulses (now %b), required 2 (now 0)", n_clr - clr0, bus.clr_rx_rdy);
    end
    total++;
    if (n_to !== to0) begin
      bad++;
      $display("FAIL basic_no_timeout: got %0d pulses, required 0", n_to - to0);
    end
  endtask

  task automatic test_clr_cmd();
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_cmd_rdy = 1'b0;
    total++;
    if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'hA53C) begin
      bad++;
      $display("FAIL clr_cmd_rdy: rdy=%b cmd=%h, required rdy=0 cmd=A53C", bus.cmd_rdy, bus.cmd);
    end
  endtask

  task automatic test_timeout();
    bit took; longint t; logic [15:0] c; logic r; int to0;
    to0 = n_to;
    send_byte(8'h12, 0, 0, took, t, c, r);
    // Byte taken at edge E; we are now just after E+1, timeout fires at E+TO.
    repeat (TO - 2) @(posedge clk);
    #1;
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: timeout_err=%b one cycle before terminal, required 0", bus.timeout_err);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_pulse: timeout_err=%b at terminal count, required 1", bus.timeout_err);
    end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (n_to - to0 !== 1 || bus.cmd !== 16'hA53C || bus.cmd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_state: pulses=%0d cmd=%h rdy=%b, required 1 A53C 0", n_to - to0, bus.cmd, bus.cmd_rdy);
    end
    send_byte(8'h56, 0, 0, took, t, c, r);
    send_byte(8'h78, 0, 0, took, t, c, r);
    total++;
    if (c !== 16'h5678 || r !== 1'b1) begin
      bad++;
      $display("FAIL after_timeout_cmd: cmd=%h rdy=%b, required 5678 rdy=1", c, r);
    end
  endtask

  task automatic test_set_wins();
    bit took; longint t; logic [15:0] c; logic r;
    send_byte(8'h11, 0, 0, took, t, c, r);
    total++;
    if (r !== 1'b0 || c !== 16'h5678) begin
      bad++;
      $display("FAIL hi_clears_rdy: rdy=%b cmd=%h, required 0 5678", r, c);
    end
    send_byte(8'hFF, 2, 1, took, t, c, r);
    total++;
    if (c !== 16'h11FF || r !== 1'b1) begin
      bad++;
      $display("FAIL set_wins: cmd=%h rdy=%b, required 11FF rdy=1", c, r);
    end
  endtask

  task automatic test_terminal();
    bit took; longint t0, t1; logic [15:0] c; logic r; int to0;
    to0 = n_to;
    send_byte(8'h9A, 0, 0, took, t0, c, r);
    send_byte(8'hBC, TO - 2, 0, took, t1, c, r);
    total++;
    if (c !== 16'h9ABC || r !== 1'b1 || n_to !== to0 || (t1 - t0) / 10 !== TO) begin
      bad++;
      $display("FAIL terminal_cycle_byte: cmd=%h rdy=%b to=%0d gap=%0d, required 9ABC 1 0 %0d",
               c, r, n_to - to0, (t1 - t0) / 10, TO);
    end
    send_byte(8'hDE, 0, 0, took, t0, c, r);
    send_byte(8'hF0, TO - 1, 0, took, t1, c, r);
    total++;
    if (c !== 16'h9ABC || r !== 1'b0 || n_to - to0 !== 1) begin
      bad++;
      $display("FAIL one_past_terminal: cmd=%h rdy=%b to=%0d, required 9ABC 0 1", c, r, n_to - to0);
    end
    send_byte(8'h0F, 0, 0, took, t1, c, r);
    total++;
    if (c !== 16'hF00F || r !== 1'b1) begin
      bad++;
      $display("FAIL restart_after_timeout: cmd=%h rdy=%b, required F00F 1", c, r);
    end
  endtask

  task automatic test_tx();
    int tr0;
    tr0 = n_trmt;
    @(negedge clk);
    bus.send_resp = 1'b1; bus.resp = 8'hA5;
    @(posedge clk); #1;
    bus.send_resp = 1'b0;
    total++;
    if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL tx_start: trmt=%b tx_data=%h, required 1 A5", bus.trmt, bus.tx_data);
    end
    @(negedge clk);
    bus.send_resp = 1'b1; bus.resp = 8'h5A;
    @(posedge clk); #1;
    bus.send_resp = 1'b0;
    total++;
    if (bus.trmt !== 1'b0 || bus.tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL tx_busy_ignore: trmt=%b tx_data=%h, required 0 A5", bus.trmt, bus.tx_data);
    end
    repeat (3) @(negedge clk);
    bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.resp_sent !== 1'b1 || bus.tx_data !== 8'hA5 || n_trmt - tr0 !== 1) begin
      bad++;
      $display("FAIL tx_done: resp_sent=%b tx_data=%h trmt_pulses=%0d, required 1 A5 1",
               bus.resp_sent, bus.tx_data, n_trmt - tr0);
    end
    @(negedge clk);
    bus.send_resp = 1'b1; bus.resp = 8'h3C;
    @(posedge clk); #1;
    bus.send_resp = 1'b0;
    total++;
    if (bus.resp_sent !== 1'b0 || bus.trmt !== 1'b1 || bus.tx_data !== 8'h3C) begin
      bad++;
      $display("FAIL tx_second: resp_sent=%b trmt=%b tx_data=%h, required 0 1 3C",
               bus.resp_sent, bus.trmt, bus.tx_data);
    end
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit took; longint t; logic [15:0] c; logic r; int to0;
    send_byte(8'h33, 0, 0, took, t, c, r);
    @(negedge clk);
    bus.send_resp = 1'b1; bus.resp = 8'h77;
    @(posedge clk); #1;
    bus.send_resp = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.cmd, bus.cmd_rdy, bus.clr_rx_rdy, bus.trmt, bus.tx_data, bus.resp_sent, bus.timeout_err} !== 30'd0) begin
      bad++;
      $display("FAIL reset_mid: cmd=%h cmd_rdy=%b clr=%b trmt=%b tx_data=%h resp_sent=%b to=%b, all required 0",
               bus.cmd, bus.cmd_rdy, bus.clr_rx_rdy, bus.trmt, bus.tx_data, bus.resp_sent, bus.timeout_err);
    end
    @(negedge clk);
    rst = 1'b0;
    to0 = n_to;
    send_byte(8'h01, 0, 0, took, t, c, r);
    send_byte(8'h02, 3, 0, took, t, c, r);
    total++;
    if (c !== 16'h0102 || r !== 1'b1 || n_to !== to0) begin
      bad++;
      $display("FAIL post_reset_cmd: cmd=%h rdy=%b to=%0d, required 0102 1 0", c, r, n_to - to0);
    end
    @(negedge clk);
    bus.send_resp = 1'b1; bus.resp = 8'h42;
    @(posedge clk); #1;
    bus.send_resp = 1'b0;
    total++;
    if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h42) begin
      bad++;
      $display("FAIL post_reset_tx: trmt=%b tx_data=%h, required 1 42", bus.trmt, bus.tx_data);
    end
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  // Reference: bytes pair up when the low one is taken within TO cycles of
  // the high one; otherwise the pending high byte is dropped with one timeout.
  task automatic test_random();
    bit took; longint t, hi_t; logic [15:0] c; logic r;
    logic [7:0] b, hi_b;
    bit have_hi;
    logic [15:0] last_cmd;
    int exp_to, to0, clr0, nbytes, errs;
    have_hi = 0; hi_b = 8'h00; hi_t = 0; exp_to = 0; errs = 0;
    last_cmd = 16'h0102;
    to0 = n_to; clr0 = n_clr;
    nbytes = 40;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      send_byte(b, int'($urandom_range(0, 17)), 0, took, t, c, r);
      if (have_hi && (t - hi_t) / 10 <= TO) begin
        last_cmd = {hi_b, b};
        have_hi = 0;
        total++;
        if (!took || c !== last_cmd || r !== 1'b1) begin
          bad++; errs++;
          if (errs < 5)
            $display("FAIL rand_pair[%0d]: cmd=%h rdy=%b took=%b, required %h 1 1", i, c, r, took, last_cmd);
        end
      end else begin
        if (have_hi) exp_to++;
        have_hi = 1; hi_b = b; hi_t = t;
        total++;
        if (!took || c !== last_cmd || r !== 1'b0) begin
          bad++; errs++;
          if (errs < 5)
            $display("FAIL rand_hi[%0d]: cmd=%h rdy=%b took=%b, required %h 0 1", i, c, r, took, last_cmd);
        end
      end
    end
    repeat (TO + 4) @(negedge clk);
    if (have_hi) exp_to++;
    total++;
    if (n_to - to0 !== exp_to || n_clr - clr0 !== nbytes) begin
      bad++;
      $display("FAIL rand_counts: timeouts=%0d clr_pulses=%0d, required %0d %0d",
               n_to - to0, n_clr - clr0, exp_to, nbytes);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0; bus.resp = 8'h00; bus.tx_done = 1'b0;
    test_reset();
    test_basic();
    test_clr_cmd();
    test_timeout();
    test_set_wins();
    test_terminal();
    test_tx();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
